// File: rtl/flip_flop_d.sv
// Parameterised rising-edge D register with synchronous active-high reset.
// Define FLIPFLOPD_CE_EN to add a clock-enable input (enable); reset still wins.
module flip_flop_d #(
    parameter int          WIDTH       = 32,
    parameter logic [63:0] RESET_VALUE = 64'd0
) (
    input  logic             clock,
    input  logic             reset,
`ifdef FLIPFLOPD_CE_EN
    input  logic             enable,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Wider reset values are truncated; narrower ones arrive zero-extended.
    localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
`ifdef FLIPFLOPD_CE_EN
        if (enable) q_d = D;
`else
        q_d = D;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) q_q <= RST_VAL;
        else       q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: tb/tb_flip_flop_d.sv
// Directed bench for flip_flop_d: default 32-bit instance plus an 8-bit one
// with a truncated non-zero reset value. Enable tests run under FLIPFLOPD_CE_EN.
module tb_flip_flop_d;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] D;
    logic [31:0] Q;
    logic [7:0]  D8;
    logic [7:0]  Q8;
`ifdef FLIPFLOPD_CE_EN
    logic        enable;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #50 clock = ~clock;

    flip_flop_d dut (
        .clock (clock),
        .reset (reset),
`ifdef FLIPFLOPD_CE_EN
        .enable(enable),
`endif
        .D     (D),
        .Q     (Q)
    );

    flip_flop_d #(.WIDTH(8), .RESET_VALUE(64'h1234)) dut8 (
        .clock (clock),
        .reset (reset),
`ifdef FLIPFLOPD_CE_EN
        .enable(enable),
`endif
        .D     (D8),
        .Q     (Q8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    // Inputs change 10 ns after a falling edge; outputs sampled 1 ns after a rising edge.
    task automatic drive_slot();
        @(negedge clock);
        #10;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] pats [5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hA5A5_A5A5,
                              32'h0000_0001, 32'h5A5A_5A5A};

    initial begin
        reset = 1'b1;
        D     = '0;
        D8    = '0;
`ifdef FLIPFLOPD_CE_EN
        enable = 1'b1;
`endif
        step();
        chk("reset", Q, 32'd0);
        chk("reset8", {24'd0, Q8}, 32'h34);

        drive_slot();
        reset = 1'b0;
        D     = 32'd83745;
        D8    = 8'hC3;
        step();
        chk("load", Q, 32'd83745);
        chk("load8", {24'd0, Q8}, 32'hC3);

        // D wiggles between edges; only the value present at the edge lands.
        @(negedge clock);
        #1;
        chk("fall_hold", Q, 32'd83745);
        #9  D = 32'd123;
        #20 chk("mid_hold", Q, 32'd83745);
        #9  D = 32'd12035;
        step();
        chk("no_glitch", Q, 32'd12035);

        drive_slot();
        reset = 1'b1;
        #10 chk("rst_not_async", Q, 32'd12035);
        step();
        chk("sync_rst", Q, 32'd0);
        chk("sync_rst8", {24'd0, Q8}, 32'h34);
        step();
        chk("rst_ignores_d", Q, 32'd0);

        drive_slot();
        reset = 1'b0;
        D     = 32'd1927;
        #10 chk("rst_release", Q, 32'd0);
        step();
        chk("load_after_rst", Q, 32'd1927);

        foreach (pats[i]) begin
            drive_slot();
            D  = pats[i];
            D8 = pats[i][7:0];
            step();
            chk("pattern", Q, pats[i]);
            chk("pattern8", {24'd0, Q8}, {24'd0, pats[i][7:0]});
        end

        drive_slot();
        D = 32'd1927;
        step();
        chk("reload", Q, 32'd1927);

`ifdef FLIPFLOPD_CE_EN
        drive_slot();
        enable = 1'b0;
        D      = 32'd55;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ce_hold", Q, 32'd1927);
        end
        drive_slot();
        enable = 1'b1;
        step();
        chk("ce_load", Q, 32'd55);
        drive_slot();
        enable = 1'b0;
        reset  = 1'b1;
        step();
        chk("ce_rst_prio", Q, 32'd0);
        chk("ce_rst_prio8", {24'd0, Q8}, 32'h34);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
